cim_ternary_activation: RTL and testbench



---
 rtl/cim_ternary_pkg.sv | 24 ++
 rtl/cim_ternary_activation_if.sv | 21 ++
 rtl/cim_act_lane.sv | 58 +++++
 rtl/cim_ternary_activation.sv | 115 +++++++++++
 tb/tb_cim_ternary_activation.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cim_ternary_pkg.sv
// Shared trit encodings, FSM state type and saturation limits for the
// ternary activation stage behind the RRAM CIM crossbar.
package cim_ternary_pkg;

  localparam logic [1:0] TRIT_F = 2'b10;
  localparam logic [1:0] TRIT_U = 2'b00;
  localparam logic [1:0] TRIT_T = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Two's-complement limits of a w-bit signed value (w <= 31).
  function automatic int sat_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/cim_ternary_activation_if.sv
// Crossbar-result input and trit-vector valid/ready output of the activation stage.
interface cim_ternary_activation_if #(
  parameter int COLS = 16,
  parameter int IN_W = 8
);
  logic [COLS*IN_W-1:0] mac_result;
  logic                 mac_done;
  logic [COLS*2-1:0]    out_trits;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output mac_result, mac_done, out_ready,
    input  out_trits, out_valid
  );

  modport slave (
    input  mac_result, mac_done, out_ready,
    output out_trits, out_valid
  );
endinterface

// File: rtl/cim_act_lane.sv
// One column: saturating partial-sum accumulator plus symmetric ternary
// comparator evaluated on the sum being written this cycle.
module cim_act_lane
  import cim_ternary_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12,
  parameter int THR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    accum,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  mac,
  input  logic        [THR_W-1:0] thr,
  output logic        [1:0]       trit,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(sat_min(ACC_W));

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > HI)      return ACC_W'(HI);
    else if (v < LO) return ACC_W'(LO);
    else             return ACC_W'(v);
  endfunction

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   base;
  logic signed [ACC_W:0]   wide;
  logic signed [ACC_W:0]   sum_x;
  logic signed [ACC_W:0]   thr_pos;
  logic signed [ACC_W:0]   thr_neg;

  // A load starts from zero, so the first partial never clamps.
  always_comb begin
    base    = load ? '0 : (ACC_W+1)'(acc);
    wide    = base + (ACC_W+1)'(mac);
    sum     = saturate(wide);
    sat     = accum && ((wide > HI) || (wide < LO));
    sum_x   = (ACC_W+1)'(sum);
    thr_pos = signed'((ACC_W+1)'(thr));
    thr_neg = -thr_pos;
    trit    = TRIT_U;
    if (sum_x > thr_pos)      trit = TRIT_T;
    else if (sum_x < thr_neg) trit = TRIT_F;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              acc <= '0;
    else if (clear)          acc <= '0;
    else if (load || accum)  acc <= sum;
  end

endmodule

// File: rtl/cim_ternary_activation.sv
// Accumulates row-tile partial sums per column, ternarizes the finished group
// and holds the trit vector on a valid/ready output.
module cim_ternary_activation
  import cim_ternary_pkg::*;
#(
  parameter int COLS   = 16,
  parameter int IN_W   = 8,
  parameter int ACC_W  = 12,
  parameter int TILE_W = 4,
  parameter int THR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cim_ternary_activation_if.slave bus,
  input  logic [TILE_W-1:0]     cfg_num_tiles,
  input  logic [THR_W-1:0]      cfg_threshold,
  input  logic                  clear_flags,
  output logic                  busy,
  output logic                  sat_flag,
  output logic                  overrun_flag
);

  state_t              state;
  logic [TILE_W-1:0]   cnt;
  logic [TILE_W-1:0]   cnt_nxt;
  logic [TILE_W-1:0]   num_lat;
  logic [TILE_W-1:0]   num_eff;
  logic [THR_W-1:0]    thr_lat;
  logic [THR_W-1:0]    thr_use;
  logic                handshake;
  logic                start;
  logic                step;
  logic                drop;
  logic                clear_acc;
  logic                finalize;
  logic [COLS*2-1:0]   trits;
  logic [COLS-1:0]     sat_vec;

  // A group can start from IDLE or back-to-back with the HOLD handshake; the
  // starting partial must see the fresh config, hence thr_use bypasses thr_lat.
  always_comb begin
    handshake = bus.out_valid && bus.out_ready;
    start     = bus.mac_done && ((state == IDLE) || ((state == HOLD) && handshake));
    step      = bus.mac_done && (state == ACCUM);
    drop      = bus.mac_done && (state == HOLD) && !handshake;
    clear_acc = (state == HOLD) && handshake && !bus.mac_done;
    num_eff   = (cfg_num_tiles == '0) ? TILE_W'(1) : cfg_num_tiles;
    cnt_nxt   = cnt + 1'b1;
    thr_use   = start ? cfg_threshold : thr_lat;
    finalize  = (start && (num_eff == TILE_W'(1))) || (step && (cnt_nxt == num_lat));
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    cim_act_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .THR_W (THR_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (start),
      .accum (step),
      .clear (clear_acc),
      .mac   (signed'(bus.mac_result[c*IN_W +: IN_W])),
      .thr   (thr_use),
      .trit  (trits[c*2 +: 2]),
      .sat   (sat_vec[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      num_lat       <= '0;
      thr_lat       <= '0;
      bus.out_trits <= '0;
      bus.out_valid <= 1'b0;
      sat_flag      <= 1'b0;
      overrun_flag  <= 1'b0;
    end else begin
      if (start) begin
        num_lat <= num_eff;
        thr_lat <= cfg_threshold;
        cnt     <= TILE_W'(1);
      end else if (step) begin
        cnt <= cnt_nxt;
      end else if (clear_acc) begin
        cnt <= '0;
      end

      if (finalize) begin
        bus.out_trits <= trits;
        bus.out_valid <= 1'b1;
        state         <= HOLD;
      end else if (start || step) begin
        bus.out_valid <= 1'b0;
        state         <= ACCUM;
      end else if (clear_acc) begin
        bus.out_valid <= 1'b0;
        state         <= IDLE;
      end

      // Set events take priority over a coincident clear.
      if (step && (|sat_vec)) sat_flag <= 1'b1;
      else if (clear_flags)   sat_flag <= 1'b0;

      if (drop)             overrun_flag <= 1'b1;
      else if (clear_flags) overrun_flag <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cim_ternary_activation.sv
// Directed bench for cim_ternary_activation built with 8 columns and an 8-bit
// accumulator so that saturation is reachable.
module tb_cim_ternary_activation;

  localparam int COLS   = 8;
  localparam int IN_W   = 8;
  localparam int ACC_W  = 8;
  localparam int TILE_W = 4;
  localparam int THR_W  = 8;

  logic              clk;
  logic              rst_n;
  logic [TILE_W-1:0] cfg_num_tiles;
  logic [THR_W-1:0]  cfg_threshold;
  logic              clear_flags;
  logic              busy;
  logic              sat_flag;
  logic              overrun_flag;

  int n_total;
  int n_pass;

  cim_ternary_activation_if #(.COLS(COLS), .IN_W(IN_W)) bus ();

  cim_ternary_activation #(
    .COLS   (COLS),
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .TILE_W (TILE_W),
    .THR_W  (THR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .cfg_num_tiles (cfg_num_tiles),
    .cfg_threshold (cfg_threshold),
    .clear_flags   (clear_flags),
    .busy          (busy),
    .sat_flag      (sat_flag),
    .overrun_flag  (overrun_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TILE_W-1:0] tiles;
    logic [THR_W-1:0]  thr;
    logic [63:0]       mac;
    logic [15:0]       exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [63:0] mk(input int v0, v1, v2, v3, v4, v5, v6, v7);
    int          v [8];
    logic [63:0] r;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = v[i][7:0];
    return r;
  endfunction

  // Expected trits from -1/0/+1 per column.
  function automatic logic [15:0] tr(input int t0, t1, t2, t3, t4, t5, t6, t7);
    int          t [8];
    logic [15:0] r;
    t = '{t0, t1, t2, t3, t4, t5, t6, t7};
    r = '0;
    for (int i = 0; i < 8; i++)
      r[i*2 +: 2] = (t[i] > 0) ? 2'b01 : ((t[i] < 0) ? 2'b10 : 2'b00);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] m);
    bus.mac_result = m;
    bus.mac_done   = 1'b1;
    step();
    bus.mac_done   = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n          = 1'b0;
    cfg_num_tiles  = '0;
    cfg_threshold  = '0;
    clear_flags    = 1'b0;
    bus.mac_result = '0;
    bus.mac_done   = 1'b0;
    bus.out_ready  = 1'b1;

    tbl[0] = '{4'd1, 8'd3,   mk(5, -5, 3, -3, 0, 4, -4, 127),     tr(1, -1, 0, 0, 0, 1, -1, 1)};
    tbl[1] = '{4'd0, 8'd0,   mk(1, -1, 0, -128, 127, 0, 2, -2),   tr(1, -1, 0, -1, 1, 0, 1, -1)};
    tbl[2] = '{4'd1, 8'd255, mk(127, -128, 0, 1, -1, 0, 0, 0),    tr(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3] = '{4'd1, 8'd126, mk(127, -127, 126, -126, -128, 0, 0, 0), tr(1, -1, 0, 0, -1, 0, 0, 0)};
    tbl[4] = '{4'd1, 8'd127, mk(127, -128, -127, 0, 0, 0, 0, 0),  tr(0, -1, 0, 0, 0, 0, 0, 0)};

    step();
    step();
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_trits", 64'(bus.out_trits), 64'd0);
    chk("reset busy",      64'(busy), 64'd0);
    chk("reset flags",     {62'd0, sat_flag, overrun_flag}, 64'd0);
    rst_n = 1'b1;
    step();

    // Single-tile groups, downstream always ready.
    for (int i = 0; i < 5; i++) begin
      cfg_num_tiles = tbl[i].tiles;
      cfg_threshold = tbl[i].thr;
      send(tbl[i].mac);
      chk($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d trits", i), 64'(bus.out_trits), 64'(tbl[i].exp));
      chk($sformatf("vec%0d busy", i),  64'(busy), 64'd1);
      step();
      chk($sformatf("vec%0d valid drop", i), 64'(bus.out_valid), 64'd0);
      chk($sformatf("vec%0d idle", i),       64'(busy), 64'd0);
    end
    chk("no sat after loads", 64'(sat_flag), 64'd0);

    // Three-tile group; config changes after tile 1 must be ignored.
    cfg_num_tiles = 4'd3;
    cfg_threshold = 8'd10;
    send(mk(4, -4, -4, 0, 0, 0, 0, 0));
    chk("multi t1 valid", 64'(bus.out_valid), 64'd0);
    chk("multi t1 busy",  64'(busy), 64'd1);
    cfg_num_tiles = 4'd1;
    cfg_threshold = 8'd0;
    step();
    send(mk(4, -4, -4, 0, 0, 0, 0, 0));
    chk("multi t2 valid", 64'(bus.out_valid), 64'd0);
    send(mk(4, -2, -3, 0, 0, 0, 0, 0));
    chk("multi t3 valid", 64'(bus.out_valid), 64'd1);
    chk("multi t3 trits", 64'(bus.out_trits), 64'(tr(1, 0, -1, 0, 0, 0, 0, 0)));
    step();
    chk("multi done", 64'(bus.out_valid), 64'd0);

    // Saturation in both directions, then clear.
    cfg_num_tiles = 4'd3;
    cfg_threshold = 8'd5;
    send(mk(127, -128, 1, 0, 0, 0, 0, 0));
    chk("sat t1 flag", 64'(sat_flag), 64'd0);
    send(mk(127, -128, 1, 0, 0, 0, 0, 0));
    chk("sat t2 flag", 64'(sat_flag), 64'd1);
    send(mk(127, -128, 1, 0, 0, 0, 0, 0));
    chk("sat trits", 64'(bus.out_trits), 64'(tr(1, -1, 0, 0, 0, 0, 0, 0)));
    step();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("sat cleared", 64'(sat_flag), 64'd0);

    // Overrun while pending, then back-to-back handshake with a new partial.
    bus.out_ready = 1'b0;
    cfg_num_tiles = 4'd1;
    cfg_threshold = 8'd3;
    send(mk(5, 0, -9, 0, 0, 0, 0, 0));
    chk("pend valid", 64'(bus.out_valid), 64'd1);
    send(mk(-5, 0, 9, 0, 0, 0, 0, 0));
    chk("overrun set",     64'(overrun_flag), 64'd1);
    chk("overrun trits",   64'(bus.out_trits), 64'(tr(1, 0, -1, 0, 0, 0, 0, 0)));
    chk("overrun busy",    64'(busy), 64'd1);
    bus.out_ready = 1'b1;
    send(mk(-5, 0, 9, 0, 0, 0, 0, 0));
    bus.out_ready = 1'b0;
    chk("b2b valid", 64'(bus.out_valid), 64'd1);
    chk("b2b trits", 64'(bus.out_trits), 64'(tr(-1, 0, 1, 0, 0, 0, 0, 0)));
    clear_flags = 1'b1;
    send(mk(1, 1, 1, 1, 1, 1, 1, 1));
    chk("set beats clear", 64'(overrun_flag), 64'd1);
    step();
    clear_flags = 1'b0;
    chk("overrun cleared", 64'(overrun_flag), 64'd0);
    chk("b2b trits stable", 64'(bus.out_trits), 64'(tr(-1, 0, 1, 0, 0, 0, 0, 0)));
    bus.out_ready = 1'b1;
    step();
    chk("b2b done", 64'(bus.out_valid), 64'd0);

    // Reset while a result is pending discards it.
    bus.out_ready = 1'b0;
    send(mk(50, 0, 0, 0, 0, 0, 0, 0));
    send(mk(50, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("rst hold valid",   64'(bus.out_valid), 64'd0);
    chk("rst hold trits",   64'(bus.out_trits), 64'd0);
    chk("rst hold busy",    64'(busy), 64'd0);
    chk("rst hold overrun", 64'(overrun_flag), 64'd0);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();

    // Reset during tile 2 of 4; the next group starts from zero.
    cfg_num_tiles = 4'd4;
    cfg_threshold = 8'd30;
    send(mk(50, -50, 0, 0, 0, 0, 0, 0));
    send(mk(50, -50, 0, 0, 0, 0, 0, 0));
    chk("accum busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst accum busy", 64'(busy), 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    for (int t = 0; t < 3; t++) begin
      send(mk(-10, 10, 0, 0, 0, 0, 0, 0));
      chk($sformatf("fresh t%0d valid", t + 1), 64'(bus.out_valid), 64'd0);
    end
    send(mk(-10, 10, 0, 0, 0, 0, 0, 0));
    chk("fresh valid", 64'(bus.out_valid), 64'd1);
    chk("fresh trits", 64'(bus.out_trits), 64'(tr(-1, 1, 0, 0, 0, 0, 0, 0)));
    step();
    chk("fresh done", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
